// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and a counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, first-word fall-through; pop_dat is valid whenever empty is low.
// full/empty are registered; a push while full is dropped even if a pop happens on the same edge.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (do_push && !do_pop) begin
      level_d = level + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      full  <= (level_d == LVL_W'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter; first start bit one cycle after accept, frames back-to-back.
// tx_ready drops while the queue is full; UART_TX_FIFO_EN selects a FIFO queue, else one holding register.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [1:0]                         parity_mode,
  input  logic                               two_stop,
  output logic                               tx,
  output logic                               tx_busy,
  output logic [2:0]                         tx_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_width(DATA_BITS);
  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 push;
  logic                 pop;
  logic                 q_empty;
  logic [DATA_BITS-1:0] q_dat;

  assign push = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
  logic q_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .push_dat (tx_data),
    .pop      (pop),
    .pop_dat  (q_dat),
    .full     (q_full),
    .empty    (q_empty),
    .level    (fifo_level)
  );

  assign tx_ready = !q_full;
`else
  logic                 hold_vld;
  logic [DATA_BITS-1:0] hold_dat;

  // Push and pop can never coincide: push needs the register empty, pop needs it full.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (push) begin
      hold_vld <= 1'b1;
      hold_dat <= tx_data;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign q_empty    = !hold_vld;
  assign q_dat      = hold_dat;
  assign tx_ready   = !hold_vld;
  assign fifo_level = LVL_W'(hold_vld);
`endif

  tx_state_t            state, state_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_en, par_en_d;
  logic                 par_bit, par_bit_d;
  logic                 stop2, stop2_d;
  logic                 tx_d;
  logic                 tick;
  logic                 load;

  assign tick     = (baud_cnt == BAUD_LAST);
  assign tx_busy  = (state != ST_IDLE);
  assign tx_state = state;

  always_comb begin
    state_d    = state;
    baud_cnt_d = tick ? '0 : baud_cnt + BAUD_W'(1);
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_en_d   = par_en;
    par_bit_d  = par_bit;
    stop2_d    = stop2;
    load       = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;

    case (state)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!q_empty) load = 1'b1;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            shreg_d   = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        // bit_cnt doubles as the stop-bit counter; it is zero on entry.
        if (tick) begin
          if (stop2 && (bit_cnt == '0)) begin
            bit_cnt_d = BIT_W'(1);
          end else begin
            bit_cnt_d = '0;
            if (!q_empty) load = 1'b1;
            else          state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame load: line settings are captured here and held until the next load.
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      baud_cnt_d = '0;
      shreg_d    = q_dat;
      par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_d  = (^q_dat) ^ (parity_mode == PAR_ODD);
      stop2_d    = two_stop;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      par_en   <= par_en_d;
      par_bit  <= par_bit_d;
      stop2    <= stop2_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with CLKS_PER_BIT=10, DATA_BITS=8, FIFO_DEPTH=4.
// Queue-dependent expectations follow UART_TX_FIFO_EN when it is defined for the build.
module tb_uart_tx_param;

  localparam int CPB = 10;

`ifdef UART_TX_FIFO_EN
  localparam int EXP_EARLY  = 5;
  localparam int EXP_PEAK   = 4;
  localparam int EXP_QUEUED = 2;
`else
  localparam int EXP_EARLY  = 2;
  localparam int EXP_PEAK   = 1;
  localparam int EXP_QUEUED = 1;
`endif

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx;
  logic       tx_busy;
  logic [2:0] tx_state;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  uart_tx_param #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_state    (tx_state),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte on an idle block; returns one cycle after the accepting edge.
  task automatic send(input string tag, input logic [7:0] d, input logic [1:0] pm, input logic ts);
    tx_data     = d;
    parity_mode = pm;
    two_stop    = ts;
    tx_valid    = 1'b1;
    tick1();
    tx_valid = 1'b0;
    check({tag, "_accept"}, {tx, tx_state, 29'(fifo_level)}, {1'b1, 3'd0, 29'd1});
    tick1();
  endtask

  // Walks a frame cycle by cycle; bits[j] is the expected line value of bit slot j.
  task automatic frame_check(input string tag, input logic [11:0] bits, input int nbits,
                             input bit has_par, input bit toggle);
    int         bad;
    int         j;
    logic [2:0] se;
    bad = 0;
    for (int i = 0; i < nbits * CPB; i++) begin
      j  = i / CPB;
      se = (j == 0) ? 3'd1 : (j <= 8) ? 3'd2 : (has_par && j == 9) ? 3'd3 : 3'd4;
      if (tx !== bits[j] || tx_busy !== 1'b1 || tx_state !== se) bad++;
      if (toggle && i == 50) begin
        two_stop    = ~two_stop;
        parity_mode = 2'b00;
      end
      tick1();
    end
    check({tag, "_bits"}, bad, 0);
    check({tag, "_end"}, {tx_busy, tx_state, tx}, {1'b0, 3'd0, 1'b1});
  endtask

  logic [7:0] bb [6];
  logic [7:0] rb [3];
  logic       acc;
  logic       exp_tx;
  int         idx;
  int         early;
  int         peak;
  int         bad;
  int         busy_cnt;

  initial begin
    n_rst       = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_state", tx_state, 3'd0);
    check("rst_level", fifo_level, 3'd0);
    n_rst = 1'b1;
    tick1();

    send("f55", 8'h55, 2'b00, 1'b0);
    frame_check("f55", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 1'b0, 1'b0);

    // 0xA7 has five ones: even parity bit is 1. Settings flipped mid-frame must not matter.
    send("fa7", 8'hA7, 2'b01, 1'b1);
    frame_check("fa7", {2'b11, 1'b1, 8'hA7, 1'b0}, 12, 1'b1, 1'b1);

    send("f00odd", 8'h00, 2'b10, 1'b0);
    frame_check("f00odd", {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 1'b1, 1'b0);

    send("f00rsv", 8'h00, 2'b11, 1'b0);
    frame_check("f00rsv", {2'b00, 1'b1, 8'h00, 1'b0}, 10, 1'b0, 1'b0);

    // Burst of six bytes offered from consecutive cycles, valid held until each is taken
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;
    bb[3] = 8'h44; bb[4] = 8'h55; bb[5] = 8'h66;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    idx      = 0;
    early    = 0;
    peak     = 0;
    bad      = 0;
    busy_cnt = 0;
    tx_data  = bb[0];
    tx_valid = 1'b1;
    for (int c = 0; c < 620; c++) begin
      acc = tx_valid && tx_ready;
      tick1();
      if (acc) begin
        if (c < 6) early++;
        idx++;
        if (idx == 6) tx_valid = 1'b0;
        else          tx_data  = bb[idx];
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (tx_busy === 1'b1) busy_cnt++;
      if (c >= 1 && c <= 600) begin
        int k;
        int j;
        k = (c - 1) / 100;
        j = ((c - 1) % 100) / CPB;
        exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bb[k][j-1];
        if (tx !== exp_tx || tx_busy !== 1'b1) bad++;
      end else begin
        if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      if (c == 100) check("burst_ready_full", tx_ready, 1'b0);
      if (c == 101) check("burst_ready_back", tx_ready, 1'b1);
    end
    check("burst_early_accepts", early, EXP_EARLY);
    check("burst_total_accepts", idx, 6);
    check("burst_peak_level", peak, EXP_PEAK);
    check("burst_line", bad, 0);
    check("burst_busy_cycles", busy_cnt, 600);

    // Reset at frame cycle 45 with bytes still queued
    rb[0] = 8'h00; rb[1] = 8'hC3; rb[2] = 8'h3C;
    idx      = 0;
    tx_data  = rb[0];
    tx_valid = 1'b1;
    for (int c = 0; c < 47; c++) begin
      acc = tx_valid && tx_ready;
      tick1();
      if (acc) begin
        idx++;
        if (idx == 3) tx_valid = 1'b0;
        else          tx_data  = rb[idx];
      end
    end
    check("mid_level", fifo_level, EXP_QUEUED);
    check("mid_line", {tx, tx_state}, {1'b0, 3'd2});
    tx_valid = 1'b0;
    n_rst    = 1'b0;
    tick1();
    check("mrst_tx", tx, 1'b1);
    check("mrst_level", fifo_level, 3'd0);
    check("mrst_busy_state", {tx_busy, tx_state}, {1'b0, 3'd0});
    check("mrst_ready", tx_ready, 1'b1);
    n_rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      tick1();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    check("post_rst_quiet", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter for the peripheral bus. It replaces the fixed 8-bit, even-parity, single-stop transmitter with one that has configurable data width, runtime parity mode and stop-bit count, a compile-time baud divisor, and a valid/ready write handshake. A small transmit FIFO (optional) lets the core queue several bytes without polling. It sits between the memory-mapped UART register file and the `tx` pad.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame. Legal range 5..9.
- `CLKS_PER_BIT`, 5208: clock cycles per bit time. Minimum 2. 5208 gives 9600 baud at 50 MHz.
- `FIFO_DEPTH`, 4: FIFO entries. Power of two, ≥2. Used only with `UART_TX_FIFO_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `n_rst` in 1: reset, synchronous and active-low.
- `tx_data` in DATA_BITS: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block accepts `tx_data` on this edge when `tx_valid` is also high.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `two_stop` in 1: 1 = two stop bits, 0 = one.
- `tx` out 1: serial line. Idle level is high.
- `tx_busy` out 1: a frame is on the line.
- `tx_state` out 3: FSM state for debug.
- `fifo_level` out $clog2(FIFO_DEPTH+1): number of queued entries.

## Operation
- FSM states and `tx_state` encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Transitions:
  - IDLE→START when the queue is non-empty. This pops one entry and latches `parity_mode` and `two_stop` for the whole frame.
  - START→DATA after 1 bit time.
  - DATA→PARITY after DATA_BITS bit times, if the latched parity mode is even or odd.
  - DATA→STOP after DATA_BITS bit times, otherwise.
  - PARITY→STOP after 1 bit time.
  - STOP→START after 1 or 2 bit times if the queue is non-empty (pop again, no idle gap).
  - STOP→IDLE after 1 or 2 bit times otherwise.
- Line values by state:
  - START: `tx` = 0.
  - DATA: bits are sent LSB first.
  - PARITY: even = XOR of the data bits; odd = its inverse.
  - STOP: `tx` = 1.
  - IDLE: `tx` = 1.
- Baud counter: counts 0..CLKS_PER_BIT-1, is cleared on every state entry, and advances the bit on terminal count.
- Bit counter: $clog2(DATA_BITS) bits wide; counts data bits and stop bits.
- `tx` is driven from a flop. No combinational path from any input to `tx`.
- `tx_busy` = (state ≠ IDLE).
- `tx_ready` = queue not full, taken from a registered flag. A pop and a push on the same edge while full do not admit the push.
- `parity_mode` and `two_stop` changes in mid-frame have no effect until the next frame load.

## Timing
- Reset values:
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_state`=0, `fifo_level`=0.
  - Queue pointers and all counters are zero.
- Reset mid-frame: on the first edge with `n_rst` low, `tx` returns to 1 and all queued data is discarded.
- Latency, idle with an empty queue: accept on edge E0 → pop on E1 → `tx`=0 from E1 for exactly CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + P + S) × CLKS_PER_BIT cycles, where P = 0 or 1 (parity bit present) and S = 1 or 2 (stop bits).
- Back-to-back frames: the next start bit begins on the edge after the last stop-bit cycle, with zero idle cycles.
- Full queue: `tx_ready`=0 and `tx_valid` is ignored. `tx_ready` returns high on the edge after the next pop.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - The queue is a FIFO_DEPTH-entry synchronous FIFO.
  - `fifo_level` ranges 0..FIFO_DEPTH.
- `UART_TX_FIFO_EN` undefined:
  - The queue is a single holding register, double-buffered against the shifter, so one byte can be accepted while another is being sent.
  - FIFO_DEPTH is ignored.
  - `fifo_level` is 0 or 1.
  - All other timing is identical.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (encodings above),
  - parity mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`,
  - a `clog2`-based width helper.
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, full, empty, level).
  - Instantiated only under `UART_TX_FIFO_EN`.
  - Reusable later by the receiver.
- Top module contains: FSM, baud counter, bit counter, shift register, parity generator.

## Test plan
Common setup: CLKS_PER_BIT=10, DATA_BITS=8, FIFO_DEPTH=4.
- Reset: hold `n_rst` low 3 cycles → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_state`=0, `fifo_level`=0.
- Send 0x55, parity none, one stop → `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. `tx_busy` high for 100 cycles. First low is 1 cycle after accept.
- Send 0xA7, even parity, two stop → parity bit 1 (five ones in the data). 12-bit frame, 120 cycles. Toggling `two_stop` mid-frame does not change the frame.
- Send 0x00, odd parity → parity bit 1. Send 0x00, `parity_mode`=11 → no parity bit, 100-cycle frame.
- Push 6 bytes on consecutive cycles (FIFO build) → 5 accepted, `tx_ready` low on the 6th until the first frame ends. Six frames are sent back-to-back with no idle cycles, 600 cycles total. `fifo_level` peaks at 4.
- Assert `n_rst` low at cycle 45 of a frame with 2 bytes queued → `tx`=1 on the next edge, `fifo_level`=0, and no further frames after release.
